// File: rtl/tensor_core_pkg.sv
// Shared types for the tokenizer datapath.
// Holds the SRAM arbiter state encoding.
package tensor_core_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_OWNED
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Scans last+1, last+2, ... and returns the first set request one-hot.
module rr_pick #(
  parameter int NUM_REQ = 3,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last,
  output logic [NUM_REQ-1:0] pick,
  output logic               any
);

  int idx;

  always_comb begin
    pick = '0;
    any  = 1'b0;
    idx  = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last) + k) % NUM_REQ;
      if (!any && req[IW'(idx)]) begin
        pick[IW'(idx)] = 1'b1;
        any            = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between requesters,
// with locked bursts bounded by MAX_HOLD and routed 1-cycle read return.
module sram_port_arbiter
  import tensor_core_pkg::*;
#(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_HOLD   = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req,
  input  logic [NUM_REQ-1:0]               lock,
  input  logic [NUM_REQ-1:0]               we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    din,
  output logic [NUM_REQ-1:0]               gnt,
  output logic [NUM_REQ-1:0]               rvalid,
  output logic [DATA_WIDTH-1:0]            rdata,
  output logic                             mem_cs,
  output logic                             mem_we,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic [DATA_WIDTH-1:0]            mem_din,
  input  logic [DATA_WIDTH-1:0]            mem_dout
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int HW = $clog2(MAX_HOLD + 1);

  arb_state_t         state_q, state_d;
  logic [IW-1:0]      own_q, own_d;
  logic [IW-1:0]      last_q, last_d;
  logic [IW-1:0]      pick_idx;
  logic [HW-1:0]      hold_q, hold_d;
  logic [NUM_REQ-1:0] gnt_d, rvalid_d, pick;
  logic               any, access, keep;

  // Reset suppresses any access so a pending write never reaches the SRAM.
  assign access = (state_q == ARB_OWNED) && req[own_q] && !rst;
  assign keep   = access && lock[own_q]
               && (32'(hold_q) + 1 < MAX_HOLD);
  assign last_d = access ? own_q : last_q;

  assign mem_cs   = access;
  assign mem_we   = access && we[own_q];
  assign mem_addr = access ?
    addr[own_q*ADDR_WIDTH +: ADDR_WIDTH] : '0;
  assign mem_din  = access ?
    din[own_q*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign rdata    = mem_dout;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_pick (
    .req  (req),
    .last (last_d),
    .pick (pick),
    .any  (any)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (pick[i]) pick_idx = IW'(i);
  end

  always_comb begin
    state_d  = ARB_IDLE;
    gnt_d    = '0;
    own_d    = own_q;
    hold_d   = '0;
    rvalid_d = '0;
    if (keep) begin
      state_d = ARB_OWNED;
      gnt_d   = gnt;
      hold_d  = hold_q + HW'(1);
    end else if (any) begin
      state_d = ARB_OWNED;
      gnt_d   = pick;
      own_d   = pick_idx;
    end
    if (access && !we[own_q])
      rvalid_d[own_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      gnt     <= '0;
      rvalid  <= '0;
      own_q   <= '0;
      last_q  <= IW'(NUM_REQ - 1);
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt     <= gnt_d;
      rvalid  <= rvalid_d;
      own_q   <= own_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
    end
  end

endmodule
